// File: rtl/icache_refill_ctrl_pkg.sv
// Shared defines for the I-cache refill sequencer: bus widths, the refill
// address alignment mask and the 4-bit FSM state encoding.
package icache_refill_ctrl_pkg;

  localparam int INST_ADDR_W = 64;   // InstAddrBus
  localparam int INST_W      = 64;   // InstBus

  // Refill requests are always word aligned (low two PC bits dropped).
  localparam logic [63:0] REFILL_ALIGN_MASK = ~64'h3;

  // Distance from a demand refill to the next-line prefetch.
  localparam int PF_STRIDE = 4;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_REQ     = 4'd1;
  localparam logic [3:0] ST_WAIT    = 4'd2;
  localparam logic [3:0] ST_FILL    = 4'd3;
  localparam logic [3:0] ST_DRAIN   = 4'd4;
  localparam logic [3:0] ST_ERR     = 4'd5;
  localparam logic [3:0] ST_PF_REQ  = 4'd6;
  localparam logic [3:0] ST_PF_WAIT = 4'd7;
  localparam logic [3:0] ST_PF_FILL = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_WAIT    = ST_WAIT,
    S_FILL    = ST_FILL,
    S_DRAIN   = ST_DRAIN,
    S_ERR     = ST_ERR,
    S_PF_REQ  = ST_PF_REQ,
    S_PF_WAIT = ST_PF_WAIT,
    S_PF_FILL = ST_PF_FILL
  } state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Blocking refill sequencer for the direct-mapped I-cache. Latches the
// missing PC, issues a single read on the memory port, writes the returned
// instruction into the cache and stalls fetch meanwhile. Handles flush and
// bus errors. Optional next-line prefetch: define ICACHE_PREFETCH_EN.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int AW = INST_ADDR_W,
  parameter int DW = INST_W
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] PcIn,
  input  logic          CacheMissing,
  input  logic          CacheFull,
  input  logic          FlushReq,
  output logic          MemReqValid,
  output logic [AW-1:0] MemReqAddr,
  input  logic          MemReqReady,
  input  logic          MemRspValid,
  input  logic [DW-1:0] MemRspData,
  input  logic          MemRspErr,
  output logic          RefillValid,
  output logic [AW-1:0] RefillAddr,
  output logic [DW-1:0] RefillData,
  output logic          FetchStall,
  output logic          FetchErr
);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_req_valid;
  logic          r_refill_valid;
  logic          r_fetch_err;
  logic          w_latch;
  logic          w_capture;
  logic          w_pf_advance;

`ifndef ICACHE_PREFETCH_EN
  // Cache occupancy only matters when deciding whether to prefetch.
  logic w_unused_cache_full;
  assign w_unused_cache_full = CacheFull;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. A request accepted in the same cycle as a flush is
  // already on the bus, so its response must be drained; a response that
  // coincides with a flush is consumed on the spot and nothing is left to drain.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (CacheMissing && !FlushReq) w_next = S_REQ;
      S_REQ: begin
        if (MemReqReady)   w_next = FlushReq ? S_DRAIN : S_WAIT;
        else if (FlushReq) w_next = S_IDLE;
      end
      S_WAIT: begin
        if (FlushReq)         w_next = MemRspValid ? S_IDLE : S_DRAIN;
        else if (MemRspValid) w_next = MemRspErr ? S_ERR : S_FILL;
      end
`ifdef ICACHE_PREFETCH_EN
      S_FILL:  w_next = (!CacheFull && !FlushReq) ? S_PF_REQ : S_IDLE;
`else
      S_FILL:  w_next = S_IDLE;
`endif
      S_DRAIN: if (MemRspValid) w_next = S_IDLE;
      S_ERR:   if (FlushReq) w_next = S_IDLE;
`ifdef ICACHE_PREFETCH_EN
      S_PF_REQ: begin
        if (MemReqReady)   w_next = FlushReq ? S_DRAIN : S_PF_WAIT;
        else if (FlushReq) w_next = S_IDLE;
      end
      S_PF_WAIT: begin
        // Prefetch errors are dropped silently; no fault is reported.
        if (FlushReq)         w_next = MemRspValid ? S_IDLE : S_DRAIN;
        else if (MemRspValid) w_next = MemRspErr ? S_IDLE : S_PF_FILL;
      end
      S_PF_FILL: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign w_latch   = (r_state == S_IDLE) && (w_next == S_REQ);
`ifdef ICACHE_PREFETCH_EN
  assign w_pf_advance = (r_state == S_FILL) && (w_next == S_PF_REQ);
  assign w_capture    = ((r_state == S_WAIT)    && (w_next == S_FILL)) ||
                        ((r_state == S_PF_WAIT) && (w_next == S_PF_FILL));
`else
  assign w_pf_advance = 1'b0;
  assign w_capture    = (r_state == S_WAIT) && (w_next == S_FILL);
`endif

  // Refill address: latched once per miss, PcIn changes afterwards ignored.
  always_ff @(posedge Clk) begin
    if (!Rst)              r_addr <= '0;
    else if (w_latch)      r_addr <= PcIn & REFILL_ALIGN_MASK[AW-1:0];
    else if (w_pf_advance) r_addr <= r_addr + AW'(PF_STRIDE);
  end

  // Response data capture for the fill cycle.
  always_ff @(posedge Clk) begin
    if (!Rst)           r_data <= '0;
    else if (w_capture) r_data <= MemRspData;
  end

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_req_valid    <= 1'b0;
      r_refill_valid <= 1'b0;
      r_fetch_err    <= 1'b0;
    end else begin
      r_req_valid    <= (w_next == S_REQ)  || (w_next == S_PF_REQ);
      r_refill_valid <= (w_next == S_FILL) || (w_next == S_PF_FILL);
      r_fetch_err    <= (w_next == S_ERR);
    end
  end

  // Fetch stall: combinational only where fetch may run (idle or prefetch).
  always_comb begin
    FetchStall = 1'b1;
    case (r_state)
      S_IDLE, S_PF_REQ, S_PF_WAIT, S_PF_FILL: FetchStall = CacheMissing;
      default:                                FetchStall = 1'b1;
    endcase
  end

  assign MemReqValid = r_req_valid;
  assign MemReqAddr  = r_addr;
  assign RefillValid = r_refill_valid;
  assign RefillAddr  = r_addr;
  assign RefillData  = r_data;
  assign FetchErr    = r_fetch_err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed stimulus pushes expected
// bus requests and cache fills into queues; a monitor pops and compares them
// whenever the DUT presents an accepted request or a refill write.
// Prefetch scenarios are included when ICACHE_PREFETCH_EN is defined.
module tb_icache_refill_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [63:0] PcIn = '0;
  logic        CacheMissing = 1'b0;
  logic        CacheFull = 1'b1;
  logic        FlushReq = 1'b0;
  logic        MemReqValid;
  logic [63:0] MemReqAddr;
  logic        MemReqReady = 1'b0;
  logic        MemRspValid = 1'b0;
  logic [63:0] MemRspData = '0;
  logic        MemRspErr = 1'b0;
  logic        RefillValid;
  logic [63:0] RefillAddr;
  logic [63:0] RefillData;
  logic        FetchStall;
  logic        FetchErr;

  int checks = 0;
  int errors = 0;

  logic [63:0]  exp_req[$];
  logic [127:0] exp_fill[$];

  icache_refill_ctrl dut (
    .Clk(Clk), .Rst(Rst), .PcIn(PcIn), .CacheMissing(CacheMissing),
    .CacheFull(CacheFull), .FlushReq(FlushReq),
    .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData), .MemRspErr(MemRspErr),
    .RefillValid(RefillValid), .RefillAddr(RefillAddr), .RefillData(RefillData),
    .FetchStall(FetchStall), .FetchErr(FetchErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Move to just after the next active edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: accepted requests and refill writes against the scoreboard.
  always @(negedge Clk) begin
    if (Rst && MemReqValid && MemReqReady) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %0h expected no request", MemReqAddr);
      end else chk("req_addr_sb", MemReqAddr, exp_req.pop_front());
    end
    if (Rst && RefillValid) begin
      if (exp_fill.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fill: got %0h/%0h expected no refill", RefillAddr, RefillData);
      end else chk("fill_sb", {RefillAddr, RefillData}, exp_fill.pop_front());
    end
  end

  // Full zero-wait miss starting from IDLE; leaves the DUT at cycle n+4.
  task automatic do_miss(input logic [63:0] pc, input logic [63:0] d);
    logic [63:0] a;
    a = {pc[63:2], 2'b00};
    exp_req.push_back(a);
    PcIn = pc; CacheMissing = 1'b1; MemReqReady = 1'b1;   // cycle n
    chk("stall_idle_miss", FetchStall, 1);
    step();                                               // n+1: REQ
    chk("req_valid", MemReqValid, 1);
    chk("req_addr", MemReqAddr, a);
    step();                                               // n+2: WAIT
    MemReqReady = 1'b0; MemRspValid = 1'b1; MemRspData = d;
    exp_fill.push_back({a, d});
    chk("req_single", MemReqValid, 0);
    step();                                               // n+3: FILL
    MemRspValid = 1'b0; CacheMissing = 1'b0;
    chk("refill_valid", RefillValid, 1);
    step();                                               // n+4: hit
    chk("stall_after_fill", FetchStall, 0);
    chk("refill_one_cycle", RefillValid, 0);
  endtask

  initial begin
    // Reset values
    Rst = 1'b0;
    step(); step();
    chk("rst_req_valid", MemReqValid, 0);
    chk("rst_req_addr", MemReqAddr, 0);
    chk("rst_refill_valid", RefillValid, 0);
    chk("rst_refill_addr", RefillAddr, 0);
    chk("rst_refill_data", RefillData, 0);
    chk("rst_fetch_err", FetchErr, 0);
    chk("rst_fetch_stall", FetchStall, 0);
    Rst = 1'b1;
    step();

    // Basic miss, immediate bus
    do_miss(64'h8000_0004, 64'h0000_0013);
    chk("no_prefetch_full", MemReqValid, 0);

    // Ready held low 5 cycles; unaligned PC; PcIn moves after latch
    exp_req.push_back(64'h2000_0010);
    PcIn = 64'h2000_0013; CacheMissing = 1'b1; MemReqReady = 1'b0;
    step();
    PcIn = 64'h5555_0000;
    for (int i = 0; i < 5; i++) begin
      chk("req_hold_valid", MemReqValid, 1);
      chk("req_hold_addr", MemReqAddr, 64'h2000_0010);
      if (i < 4) step();
    end
    MemReqReady = 1'b1;
    step();                                 // WAIT
    MemReqReady = 1'b0; MemRspValid = 1'b1; MemRspData = 64'hDEAD_BEEF_0000_ABCD;
    exp_fill.push_back({64'h2000_0010, 64'hDEAD_BEEF_0000_ABCD});
    step();                                 // FILL
    MemRspValid = 1'b0; CacheMissing = 1'b0;
    chk("stall_fill", FetchStall, 1);
    step();
    chk("stall_idle2", FetchStall, 0);

    // Flush in WAIT, response two cycles later is dropped
    exp_req.push_back(64'h300);
    PcIn = 64'h300; CacheMissing = 1'b1; MemReqReady = 1'b1;
    step();                                 // REQ
    step();                                 // WAIT
    MemReqReady = 1'b0; FlushReq = 1'b1; CacheMissing = 1'b0;
    step();                                 // DRAIN
    FlushReq = 1'b0;
    chk("stall_drain", FetchStall, 1);
    step();
    MemRspValid = 1'b1; MemRspData = 64'h1111;
    chk("stall_drain2", FetchStall, 1);
    step();                                 // IDLE
    MemRspValid = 1'b0;
    chk("idle_after_drain", FetchStall, 0);
    chk("no_fill_drain", RefillValid, 0);
    do_miss(64'h400, 64'h2222);

    // Flush coincident with response in WAIT: dropped, nothing left to drain
    exp_req.push_back(64'h700);
    PcIn = 64'h700; CacheMissing = 1'b1; MemReqReady = 1'b1;
    step(); step();                         // WAIT
    MemReqReady = 1'b0; FlushReq = 1'b1; MemRspValid = 1'b1; MemRspData = 64'h7777;
    CacheMissing = 1'b0;
    step();
    FlushReq = 1'b0; MemRspValid = 1'b0;
    chk("flush_rsp_idle", FetchStall, 0);
    chk("flush_rsp_nofill", RefillValid, 0);
    do_miss(64'h704, 64'h8888);

    // Flush in REQ before acceptance: no request issued
    PcIn = 64'h800; CacheMissing = 1'b1; MemReqReady = 1'b0;
    step();                                 // REQ
    FlushReq = 1'b1; CacheMissing = 1'b0;
    step();
    FlushReq = 1'b0;
    chk("flush_req_drop", MemReqValid, 0);
    chk("flush_req_idle", FetchStall, 0);

    // Bus error: FetchErr held until flush, no refill
    exp_req.push_back(64'h500);
    PcIn = 64'h500; CacheMissing = 1'b1; MemReqReady = 1'b1;
    step(); step();                         // WAIT
    MemReqReady = 1'b0; MemRspValid = 1'b1; MemRspErr = 1'b1;
    step();                                 // ERR
    MemRspValid = 1'b0; MemRspErr = 1'b0; CacheMissing = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("err_held", FetchErr, 1);
      chk("err_stall", FetchStall, 1);
      chk("err_no_fill", RefillValid, 0);
      step();
    end
    FlushReq = 1'b1;
    step();
    FlushReq = 1'b0;
    chk("err_cleared", FetchErr, 0);
    chk("err_idle", FetchStall, 0);

    // Reset while WAIT, then a stale response
    exp_req.push_back(64'h600);
    PcIn = 64'h600; CacheMissing = 1'b1; MemReqReady = 1'b1;
    step(); step();                         // WAIT
    MemReqReady = 1'b0; CacheMissing = 1'b0; Rst = 1'b0;
    step();
    chk("wrst_req_valid", MemReqValid, 0);
    chk("wrst_req_addr", MemReqAddr, 0);
    chk("wrst_refill_addr", RefillAddr, 0);
    chk("wrst_refill_data", RefillData, 0);
    chk("wrst_stall", FetchStall, 0);
    Rst = 1'b1; MemRspValid = 1'b1; MemRspData = 64'h6666;
    step();
    MemRspValid = 1'b0;
    chk("stale_no_fill", RefillValid, 0);
    step();
    chk("stale_idle", FetchStall, 0);
    chk("stale_data", RefillData, 0);

`ifdef ICACHE_PREFETCH_EN
    // Next-line prefetch after a fill when the cache has room
    CacheFull = 1'b0;
    do_miss(64'h100, 64'h0101);
    chk("pf_req_valid", MemReqValid, 1);
    chk("pf_req_addr", MemReqAddr, 64'h104);
    chk("pf_no_stall", FetchStall, 0);
    exp_req.push_back(64'h104);
    MemReqReady = 1'b1;
    step();                                 // PF_WAIT
    MemReqReady = 1'b0; MemRspValid = 1'b1; MemRspData = 64'h0202;
    exp_fill.push_back({64'h104, 64'h0202});
    step();                                 // PF_FILL
    MemRspValid = 1'b0;
    chk("pf_fill", RefillValid, 1);
    step();
    CacheFull = 1'b1;
    do_miss(64'h200, 64'h0303);
    chk("pf_full_none", MemReqValid, 0);
`endif

    step(); step();
    chk("req_queue_empty", exp_req.size(), 0);
    chk("fill_queue_empty", exp_fill.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Blocking refill sequencer for the direct-mapped instruction cache. On a cache miss it latches the fetch PC, issues one read on the instruction memory port with a valid/ready request channel, waits for the response, and writes the returned instruction into the cache through the cache's write port (ReadShakeHands/PrePcIn/InstIn). It sits between the fetch stage, the I-cache and the memory bus interface. While a refill is outstanding it stalls fetch, and it handles flush/redirect and bus errors.

## Interface
- AW, 64, address width
- DW, 64, instruction/data width (matches cache line width)

- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-low
- PcIn  in  AW  current fetch PC (same signal the cache reads)
- CacheMissing  in  1  cache miss indication for PcIn
- CacheFull  in  1  all cache tag valid bits set
- FlushReq  in  1  redirect/fence.i; abandons the refill in progress
- MemReqValid  out  1  read request valid
- MemReqAddr  out  AW  read address, 4-byte aligned
- MemReqReady  in  1  bus accepts request
- MemRspValid  in  1  read response valid (always accepted)
- MemRspData  in  DW  response data
- MemRspErr  in  1  response error, qualified by MemRspValid
- RefillValid  out  1  drives cache ReadShakeHands
- RefillAddr  out  AW  drives cache PrePcIn
- RefillData  out  DW  drives cache InstIn
- FetchStall  out  1  fetch must hold PC
- FetchErr  out  1  access fault on fetch

## Operation
- States: IDLE, REQ, WAIT, FILL, DRAIN, ERR. With prefetch enabled, also PF_REQ, PF_WAIT and PF_FILL.
- IDLE: when CacheMissing=1 and FlushReq=0, latch {PcIn[AW-1:2],2'b00} into the address register and go to REQ.
- REQ: MemReqValid=1 with the latched address. On MemReqReady, go to WAIT. If FlushReq=1 before the request is accepted, go to IDLE and issue no request.
- WAIT: on MemRspValid:
  - If MemRspErr=1, go to ERR.
  - Otherwise, capture MemRspData and go to FILL.
  - If FlushReq=1 arrives before the response, go to DRAIN.
- FILL: RefillValid=1 for exactly one cycle, with RefillAddr set to the latched address and RefillData set to the captured data. Next state is IDLE.
- DRAIN: discard the next MemRspValid beat, whatever MemRspErr is, and then go to IDLE. A FlushReq while in DRAIN has no extra effect.
- ERR: FetchErr=1 is held. No refill is written. FlushReq=1 returns the block to IDLE.
- FetchStall=1 in every state except IDLE. In IDLE, FetchStall equals CacheMissing (combinational), so fetch never consumes an instruction on a miss.
- Any PcIn change after the address is latched is ignored. The refill always writes the latched address.
- At most one request is outstanding at any time.
- Reset at any point returns the block to IDLE and clears all address/data registers. Responses that arrive after reset are ignored.

## Timing
- Reset values: MemReqValid=0, MemReqAddr=0, RefillValid=0, RefillAddr=0, RefillData=0, FetchErr=0, FetchStall=0.
- All outputs are registered except FetchStall while in IDLE.
- Miss seen in cycle n gives MemReqValid=1 in cycle n+1.
- Ready in cycle m gives WAIT from m+1.
- Response in cycle k gives RefillValid=1 in cycle k+1.
- The cache reports a hit from cycle k+2.
- Minimum miss-to-hit latency is 4 cycles with zero-wait bus.
- A simultaneous MemRspValid and FlushReq in WAIT is treated as a flush: the response is dropped and no fill happens.

## Configuration
- ICACHE_PREFETCH_EN defined:
  - After FILL, if CacheFull=0 and FlushReq=0, the block goes to PF_REQ with address latched+4.
  - PF_REQ, PF_WAIT and PF_FILL mirror REQ, WAIT and FILL.
  - FetchStall=0 during prefetch unless CacheMissing=1.
  - A new miss during prefetch waits until PF_FILL or DRAIN completes.
  - A prefetch error is silently dropped: the block goes to IDLE and FetchErr is not raised.
  - FlushReq during PF_WAIT goes to DRAIN.
- ICACHE_PREFETCH_EN undefined: the PF_* states are absent and FILL always goes to IDLE.

## Structure
- The state encoding (4-bit localparams) and the refill address alignment mask belong in the shared defines file, alongside `InstAddrBus`/`InstBus`.
- A single flat module; no sub-module is warranted. The existing MuxKeyWithDefault may be used for output selection.

## Test plan
- Miss at PC 0x8000_0004, ready and response immediate, data 0x0000_0013 -> MemReqAddr=0x8000_0004 at n+1, RefillValid pulse at n+3 with RefillData=0x13, FetchStall low at n+4.
- MemReqReady held low 5 cycles -> MemReqValid and address stable throughout, no second request.
- FlushReq in WAIT, response 2 cycles later -> no RefillValid, IDLE after the response, next miss is serviced normally.
- Response with MemRspErr=1 -> FetchErr=1 held until FlushReq, RefillValid never asserted.
- Rst=0 in WAIT, then a stale MemRspValid -> outputs at reset values, no refill.
- ICACHE_PREFETCH_EN, miss at 0x100 -> fill at 0x100, then prefetch request to 0x104 with FetchStall=0. With CacheFull=1, no prefetch is issued.
